// File: rtl/instruction_decode_unit.sv
// Instruction decode stage: fetches from code ROM, reads both operands from data RAM,
// forwards in-flight write-back data into held operands and issues one instruction per pulse.
module instruction_decode_unit #(
   parameter int OP_W       = 16,
   parameter int ADDR_W     = 16,
   parameter int ROM_ADDR_W = 16,
   parameter int ROW_W      = 96,
   parameter logic [OP_W-1:0] RETURN_OP = 16'h0001
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     iEnable,
   input  logic [ROM_ADDR_W-1:0]    iInitialIP,
   output logic [ROM_ADDR_W-1:0]    oInstructionAddress,
   input  logic [OP_W+3*ADDR_W-1:0] iInstruction,
   output logic [ADDR_W-1:0]        oRAMReadAddress0,
   output logic [ADDR_W-1:0]        oRAMReadAddress1,
   input  logic [ROW_W-1:0]         iRAMReadData0,
   input  logic [ROW_W-1:0]         iRAMReadData1,
   input  logic                     iRAMWriteEnable,
   input  logic [ADDR_W-1:0]        iRAMWriteAddress,
   input  logic [ROW_W-1:0]         iRAMWriteData,
   input  logic                     iExeBusy,
   input  logic                     iJumpFlag,
   input  logic [ROM_ADDR_W-1:0]    iJumpIp,
   output logic                     oDecodeDone,
   output logic [OP_W-1:0]          oOperation,
   output logic [ADDR_W-1:0]        oDestination,
   output logic [ROW_W-1:0]         oSource0,
   output logic [ROW_W-1:0]         oSource1,
   output logic [ROM_ADDR_W-1:0]    oCurrentIP,
   output logic                     oDone
);

   typedef enum logic [2:0] {IDLE, FETCH, ROM_WAIT, OPERAND_WAIT, ISSUE, HALT} state_t;

   localparam logic [ROM_ADDR_W-1:0] IP_ONE = 1;

   state_t                  state, next_state;
   logic [ROM_ADDR_W-1:0]   ip;
   logic [OP_W-1:0]         op;
   logic [ADDR_W-1:0]       dest, src0, src1;
   logic [ROW_W-1:0]        opnd0, opnd1, fwd_data0, fwd_data1;
   logic                    fwd0, fwd1;
   logic                    issue;
   logic                    wr_hit0, wr_hit1;
   logic [ADDR_W-1:0]       sel0, sel1;

   wire [OP_W-1:0]   ins_op   = iInstruction[OP_W+3*ADDR_W-1:3*ADDR_W];
   wire [ADDR_W-1:0] ins_dest = iInstruction[3*ADDR_W-1:2*ADDR_W];
   wire [ADDR_W-1:0] ins_src1 = iInstruction[2*ADDR_W-1:ADDR_W];
   wire [ADDR_W-1:0] ins_src0 = iInstruction[ADDR_W-1:0];

   // RAM read addresses come straight off the ROM word while it is first valid.
   always_comb begin
      sel0    = (state == ROM_WAIT) ? ins_src0 : src0;
      sel1    = (state == ROM_WAIT) ? ins_src1 : src1;
      wr_hit0 = iRAMWriteEnable && (iRAMWriteAddress == sel0);
      wr_hit1 = iRAMWriteEnable && (iRAMWriteAddress == sel1);
   end

   assign oRAMReadAddress0    = sel0;
   assign oRAMReadAddress1    = sel1;
   assign oInstructionAddress = ip;
   assign oCurrentIP          = ip;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      issue      = 1'b0;
      case (state)
         IDLE:         if (iEnable) next_state = FETCH;
         FETCH:        next_state = iJumpFlag ? FETCH : ROM_WAIT;
         ROM_WAIT:     next_state = iJumpFlag ? FETCH : OPERAND_WAIT;
         OPERAND_WAIT: next_state = iJumpFlag ? FETCH : ISSUE;
         ISSUE: begin
            if (iJumpFlag) next_state = FETCH;
            else if (!iExeBusy) begin
               issue      = 1'b1;
               next_state = (op == RETURN_OP) ? HALT : FETCH;
            end
         end
         HALT:         if (iEnable) next_state = FETCH;
         default:      next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         ip           <= '0;
         op           <= '0;
         dest         <= '0;
         src0         <= '0;
         src1         <= '0;
         opnd0        <= '0;
         opnd1        <= '0;
         fwd0         <= 1'b0;
         fwd1         <= 1'b0;
         fwd_data0    <= '0;
         fwd_data1    <= '0;
         oDecodeDone  <= 1'b0;
         oOperation   <= '0;
         oDestination <= '0;
         oSource0     <= '0;
         oSource1     <= '0;
         oDone        <= 1'b0;
      end else begin
         oDecodeDone <= issue;
         case (state)
            IDLE, HALT: begin
               if (iEnable) begin
                  ip    <= iInitialIP;
                  oDone <= 1'b0;
               end
            end
            FETCH: begin
               fwd0 <= 1'b0;
               fwd1 <= 1'b0;
            end
            ROM_WAIT: begin
               op   <= ins_op;
               dest <= ins_dest;
               src0 <= ins_src0;
               src1 <= ins_src1;
               // The RAM returns stale data for a write landing this cycle; remember it.
               if (wr_hit0) begin
                  fwd0      <= 1'b1;
                  fwd_data0 <= iRAMWriteData;
               end
               if (wr_hit1) begin
                  fwd1      <= 1'b1;
                  fwd_data1 <= iRAMWriteData;
               end
            end
            OPERAND_WAIT: begin
               opnd0 <= wr_hit0 ? iRAMWriteData : (fwd0 ? fwd_data0 : iRAMReadData0);
               opnd1 <= wr_hit1 ? iRAMWriteData : (fwd1 ? fwd_data1 : iRAMReadData1);
            end
            ISSUE: begin
               if (wr_hit0) opnd0 <= iRAMWriteData;
               if (wr_hit1) opnd1 <= iRAMWriteData;
               if (issue) begin
                  oOperation   <= op;
                  oDestination <= dest;
                  oSource0     <= wr_hit0 ? iRAMWriteData : opnd0;
                  oSource1     <= wr_hit1 ? iRAMWriteData : opnd1;
                  ip           <= ip + IP_ONE;
                  if (op == RETURN_OP) oDone <= 1'b1;
               end
            end
            default: ;
         endcase
         if (iJumpFlag && (state inside {FETCH, ROM_WAIT, OPERAND_WAIT, ISSUE}))
            ip <= iJumpIp;
      end
   end

endmodule

// File: tb/tb_instruction_decode_unit.sv
// Directed bench for instruction_decode_unit with a behavioural ROM and a read-only RAM image.
module tb_instruction_decode_unit;

   logic         Clock = 1'b0;
   logic         Reset;
   logic         iEnable;
   logic [15:0]  iInitialIP;
   logic [15:0]  oInstructionAddress;
   logic [63:0]  iInstruction = '0;
   logic [15:0]  oRAMReadAddress0, oRAMReadAddress1;
   logic [95:0]  iRAMReadData0 = '0, iRAMReadData1 = '0;
   logic         iRAMWriteEnable;
   logic [15:0]  iRAMWriteAddress;
   logic [95:0]  iRAMWriteData;
   logic         iExeBusy;
   logic         iJumpFlag;
   logic [15:0]  iJumpIp;
   logic         oDecodeDone;
   logic [15:0]  oOperation, oDestination;
   logic [95:0]  oSource0, oSource1;
   logic [15:0]  oCurrentIP;
   logic         oDone;

   int errors = 0;
   int checks = 0;
   int n;

   localparam logic [95:0] W0 = 96'h11111111_22222222_33333333;
   localparam logic [95:0] W1 = 96'h3F800000_00000000_40000000;
   localparam logic [95:0] W2 = 96'h3F800000_00000000_40000001;

   instruction_decode_unit dut (
      .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iInitialIP(iInitialIP),
      .oInstructionAddress(oInstructionAddress), .iInstruction(iInstruction),
      .oRAMReadAddress0(oRAMReadAddress0), .oRAMReadAddress1(oRAMReadAddress1),
      .iRAMReadData0(iRAMReadData0), .iRAMReadData1(iRAMReadData1),
      .iRAMWriteEnable(iRAMWriteEnable), .iRAMWriteAddress(iRAMWriteAddress),
      .iRAMWriteData(iRAMWriteData), .iExeBusy(iExeBusy), .iJumpFlag(iJumpFlag),
      .iJumpIp(iJumpIp), .oDecodeDone(oDecodeDone), .oOperation(oOperation),
      .oDestination(oDestination), .oSource0(oSource0), .oSource1(oSource1),
      .oCurrentIP(oCurrentIP), .oDone(oDone)
   );

   always #5 Clock = ~Clock;

   function automatic logic [63:0] rom_word(input logic [15:0] a);
      case (a)
         16'h0005: rom_word = {16'h0010, 16'h0011, 16'h0012, 16'h0013};
         16'h0006: rom_word = {16'h0020, 16'h0021, 16'h0022, 16'h0023};
         16'h0007: rom_word = {16'h0001, 16'h0071, 16'h0072, 16'h0073};
         16'h0008: rom_word = {16'h0030, 16'h0031, 16'h0020, 16'h0020};
         16'h0040: rom_word = {16'h0040, 16'h0041, 16'h0042, 16'h0043};
         16'hFFFF: rom_word = {16'h0050, 16'h0051, 16'h0052, 16'h0053};
         default:  rom_word = '0;
      endcase
   endfunction

   function automatic logic [95:0] ramf(input logic [15:0] a);
      ramf = {16'hA000, a, 16'hB000, a, 16'hC000, a};
   endfunction

   // One-cycle-latency ROM and RAM; the RAM image never changes, so reads are always stale.
   always @(posedge Clock) begin
      iInstruction  <= rom_word(oInstructionAddress);
      iRAMReadData0 <= ramf(oRAMReadAddress0);
      iRAMReadData1 <= ramf(oRAMReadAddress1);
   end

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [95:0] d);
      iRAMWriteEnable  = 1'b1;
      iRAMWriteAddress = a;
      iRAMWriteData    = d;
   endtask

   // Leaves the DUT in FETCH with IP = ip.
   task automatic start(input logic [15:0] ip);
      Reset = 1'b0;
      iEnable = 1'b0; iExeBusy = 1'b0; iJumpFlag = 1'b0; iRAMWriteEnable = 1'b0;
      step();
      Reset = 1'b1;
      iEnable = 1'b1;
      iInitialIP = ip;
      step();
      iEnable = 1'b0;
   endtask

   initial begin
      Reset = 1'b0; iEnable = 1'b0; iInitialIP = '0; iRAMWriteEnable = 1'b0;
      iRAMWriteAddress = '0; iRAMWriteData = '0; iExeBusy = 1'b0; iJumpFlag = 1'b0; iJumpIp = '0;
      step(); step();
      chk("rst_done_pulse", 128'(oDecodeDone), 128'h0);
      chk("rst_op", 128'(oOperation), 128'h0);
      chk("rst_src0", 128'(oSource0), 128'h0);
      chk("rst_addr", 128'(oInstructionAddress), 128'h0);
      chk("rst_odone", 128'(oDone), 128'h0);
      chk("rst_rdaddr0", 128'(oRAMReadAddress0), 128'h0);

      // basic issue from ROM[5]
      start(16'h0005);
      chk("fetch_addr", 128'(oInstructionAddress), 128'h5);
      step();
      chk("rd_addr0", 128'(oRAMReadAddress0), 128'h13);
      chk("rd_addr1", 128'(oRAMReadAddress1), 128'h12);
      step(); step();
      chk("no_early_pulse", 128'(oDecodeDone), 128'h0);
      step();
      chk("pulse", 128'(oDecodeDone), 128'h1);
      chk("op", 128'(oOperation), 128'h10);
      chk("dest", 128'(oDestination), 128'h11);
      chk("src0", 128'(oSource0), 128'(ramf(16'h0013)));
      chk("src1", 128'(oSource1), 128'(ramf(16'h0012)));
      chk("next_fetch", 128'(oInstructionAddress), 128'h6);
      step();
      chk("pulse_drop", 128'(oDecodeDone), 128'h0);
      chk("op_stable", 128'(oOperation), 128'h10);

      // busy hold in ISSUE
      start(16'h0006);
      iExeBusy = 1'b1;
      repeat (3) step();
      n = 0;
      repeat (10) begin step(); n += int'(oDecodeDone); end
      chk("busy_nopulse", 128'(n), 128'h0);
      chk("busy_frozen_op", 128'(oOperation), 128'h0);
      chk("busy_ip", 128'(oCurrentIP), 128'h6);
      iExeBusy = 1'b0;
      step();
      chk("busy_release_pulse", 128'(oDecodeDone), 128'h1);
      chk("busy_release_op", 128'(oOperation), 128'h20);
      chk("busy_release_src0", 128'(oSource0), 128'(ramf(16'h0023)));
      step();
      chk("busy_one_pulse", 128'(oDecodeDone), 128'h0);
      chk("busy_op_stable", 128'(oOperation), 128'h20);

      // forward: write in ROM_WAIT only, src0 == src1
      start(16'h0008);
      step(); wr(16'h0020, W0);
      step(); iRAMWriteEnable = 1'b0;
      step(); step();
      chk("fwd_rw_pulse", 128'(oDecodeDone), 128'h1);
      chk("fwd_rw_src0", 128'(oSource0), 128'(W0));
      chk("fwd_rw_src1", 128'(oSource1), 128'(W0));

      // forward: ROM_WAIT, OPERAND_WAIT and ISSUE writes, last wins
      start(16'h0008);
      step(); wr(16'h0020, W0);
      step(); wr(16'h0020, W1);
      step(); wr(16'h0020, W2);
      step(); iRAMWriteEnable = 1'b0;
      chk("fwd_last_op", 128'(oOperation), 128'h30);
      chk("fwd_last_src0", 128'(oSource0), 128'(W2));
      chk("fwd_last_src1", 128'(oSource1), 128'(W2));

      // forward: non-matching ROM_WAIT write, matching OPERAND_WAIT write
      start(16'h0008);
      step(); wr(16'h0021, W2);
      step(); wr(16'h0020, W1);
      step(); iRAMWriteEnable = 1'b0;
      step();
      chk("fwd_ow_src0", 128'(oSource0), 128'(W1));

      // non-matching write only: RAM data used
      start(16'h0008);
      repeat (3) step();
      wr(16'h0021, W2);
      step(); iRAMWriteEnable = 1'b0;
      chk("nofwd_src0", 128'(oSource0), 128'(ramf(16'h0020)));

      // jump wins over busy falling
      start(16'h0006);
      iExeBusy = 1'b1;
      repeat (5) step();
      iExeBusy = 1'b0; iJumpFlag = 1'b1; iJumpIp = 16'h0040;
      step();
      iJumpFlag = 1'b0;
      chk("jump_nopulse", 128'(oDecodeDone), 128'h0);
      chk("jump_addr", 128'(oInstructionAddress), 128'h40);
      n = 0;
      repeat (4) begin step(); n += int'(oDecodeDone); end
      chk("jump_one_issue", 128'(n), 128'h1);
      chk("jump_target_op", 128'(oOperation), 128'h40);

      // RETURN halts the program
      start(16'h0007);
      repeat (3) step();
      chk("ret_done_before", 128'(oDone), 128'h0);
      step();
      chk("ret_pulse", 128'(oDecodeDone), 128'h1);
      chk("ret_op", 128'(oOperation), 128'h1);
      chk("ret_done", 128'(oDone), 128'h1);
      n = 0;
      repeat (6) begin step(); n += int'(oDecodeDone); end
      chk("halt_nopulse", 128'(n), 128'h0);
      chk("halt_addr", 128'(oInstructionAddress), 128'h8);
      chk("halt_done_level", 128'(oDone), 128'h1);
      iEnable = 1'b1; iInitialIP = 16'h0005;
      step();
      iEnable = 1'b0;
      chk("restart_done", 128'(oDone), 128'h0);
      chk("restart_addr", 128'(oInstructionAddress), 128'h5);

      // IP wrap, then asynchronous drop of the pulse
      start(16'hFFFF);
      repeat (4) step();
      chk("wrap_pulse", 128'(oDecodeDone), 128'h1);
      chk("wrap_op", 128'(oOperation), 128'h50);
      chk("wrap_addr", 128'(oInstructionAddress), 128'h0);
      #2 Reset = 1'b0;
      #1 chk("async_pulse_drop", 128'(oDecodeDone), 128'h0);

      // reset while holding in ISSUE
      start(16'h0005);
      repeat (4) step();
      iExeBusy = 1'b1;
      repeat (3) step();
      chk("pre_rst_op", 128'(oOperation), 128'h10);
      #2 Reset = 1'b0;
      #1;
      chk("mid_rst_op", 128'(oOperation), 128'h0);
      chk("mid_rst_src0", 128'(oSource0), 128'h0);
      chk("mid_rst_addr", 128'(oInstructionAddress), 128'h0);
      chk("mid_rst_ip", 128'(oCurrentIP), 128'h0);
      iExeBusy = 1'b0;
      step();
      Reset = 1'b1;
      n = 0;
      repeat (4) begin step(); n += int'(oDecodeDone); end
      chk("post_rst_nopulse", 128'(n), 128'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
